// File: rtl/count_run_sched.sv
// count_run_sched
//
// Round-robin scheduler that shares one external loadable up-counter among
// NREQ requesters. Each grant is one "run". The counter is loaded with the
// winner's start value. It then counts up to all-ones, and the owner gets a
// one-cycle done pulse. If the owner drops its request during LOAD or COUNT,
// the run is cancelled: an abort pulse is issued and no done pulse follows.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   req        level request per requester, held until done/abort
//   req_start  packed start values, requester i at [i*WIDTH +: WIDTH]
//   cnt_out    current value of the shared counter
//   cnt_in     load value driven to the counter
//   load       counter load strobe
//   enab       counter increment enable
//   gnt        one-hot grant pulse (1 cycle, coincides with LOAD)
//   done       one-hot run-complete pulse (1 cycle, coincides with DONE)
//   abort      run-cancelled pulse (1 cycle, coincides with ABORT)
//   busy       high in any state other than IDLE
//   owner      index of the current/last owner

module count_run_sched #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_start,
    input  logic [WIDTH-1:0]         cnt_out,
    output logic [WIDTH-1:0]         cnt_in,
    output logic                     load,
    output logic                     enab,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     abort,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int          OW     = $clog2(NREQ);
    localparam int unsigned NREQ_U = NREQ;
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t            state, state_n;
    logic [OW-1:0]     ptr, ptr_n;
    logic [OW-1:0]     owner_n;
    logic [OW-1:0]     owner_inc;
    logic [OW-1:0]     win;
    logic              found;
    logic [WIDTH-1:0]  start_q, start_n;
    logic [NREQ-1:0]   gnt_n, done_n;
    logic              abort_n;
    logic              at_max;
    logic              cancel;
    logic [2*NREQ-1:0] rot;

    assign at_max    = (cnt_out == MAX);
    assign cancel    = ~req[owner];
    assign owner_inc = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // Rotate the request vector so that bit 0 corresponds to ptr. The first
    // set bit then gives the distance from ptr to the winner.
    assign rot = {req, req} >> ptr;

    always_comb begin
        int unsigned sum;
        found = 1'b0;
        win   = '0;
        sum   = 0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = 32'(ptr) + k;
                if (sum >= NREQ_U) begin
                    sum = sum - NREQ_U;
                end
                win = OW'(sum);
            end
        end
    end

    // Pulse outputs are registered. Each is therefore set on the edge that
    // enters its state, so it is visible for exactly that state's cycle.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        start_n = start_q;
        gnt_n   = '0;
        done_n  = '0;
        abort_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    owner_n = win;
                    start_n = req_start[32'(win) * WIDTH +: WIDTH];
                    gnt_n   = NREQ'(1) << win;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cancel) begin
                    abort_n = 1'b1;
                    state_n = S_ABORT;
                end else begin
                    state_n = S_COUNT;
                end
            end
            S_COUNT: begin
                // Cancellation wins over terminal detection.
                if (cancel) begin
                    abort_n = 1'b1;
                    state_n = S_ABORT;
                end else if (at_max) begin
                    done_n  = NREQ'(1) << owner;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                ptr_n   = owner_inc;
                state_n = S_IDLE;
            end
            S_ABORT: begin
                ptr_n   = owner_inc;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            start_q <= '0;
            gnt     <= '0;
            done    <= '0;
            abort   <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            start_q <= start_n;
            gnt     <= gnt_n;
            done    <= done_n;
            abort   <= abort_n;
        end
    end

    // The counter interface is driven combinationally from the state. enab
    // drops at MAX, so the counter never wraps.
    assign load   = (state == S_LOAD);
    assign enab   = (state == S_COUNT) && !at_max;
    assign cnt_in = start_q;
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_count_run_sched.sv
module tb_count_run_sched;

    localparam int W = 5;
    localparam int N = 4;
    localparam logic [W-1:0] MAXV = 5'd31;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_start = '0;
    logic [W-1:0]   cnt;
    logic [W-1:0]   cnt_in;
    logic           load, enab, abort, busy;
    logic [N-1:0]   gnt, done;
    logic [1:0]     owner;

    count_run_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .req_start(req_start),
        .cnt_out(cnt), .cnt_in(cnt_in), .load(load), .enab(enab),
        .gnt(gnt), .done(done), .abort(abort), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Shared counter model
    always @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= cnt_in;
        else if (enab) cnt <= cnt + 1'b1;
    end

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    typedef enum int {K_GNT, K_DONE, K_ABORT} kind_t;
    typedef struct {
        kind_t        kind;
        logic [N-1:0] vec;
        logic [W-1:0] start;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int gnt_cyc = 0;
    int last_end = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input kind_t k, input logic [N-1:0] v, input logic [W-1:0] s, input int lat);
        exp_t e;
        e.kind = k; e.vec = v; e.start = s; e.lat = lat;
        sbq.push_back(e);
    endtask

    // Monitor: pops one expectation per pulse the DUT presents
    always @(negedge clk) begin
        if (!rst && (gnt != '0 || done != '0 || abort)) begin
            if (sbq.size() == 0) begin
                check("unexpected_pulse", 32'({gnt, done, abort}), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                case (mon_e.kind)
                    K_GNT: begin
                        check("gnt_vec", 32'(gnt), 32'(mon_e.vec));
                        check("gnt_load", 32'(load), 32'd1);
                        check("gnt_cnt_in", 32'(cnt_in), 32'(mon_e.start));
                        check("gnt_gap", 32'((tcyc - last_end) >= 2), 32'd1);
                        gnt_cyc = tcyc;
                    end
                    K_DONE: begin
                        check("done_vec", 32'(done), 32'(mon_e.vec));
                        check("done_no_abort", 32'(abort), 32'd0);
                        check("done_lat", 32'(tcyc - gnt_cyc), 32'(mon_e.lat));
                        check("done_cnt_max", 32'(cnt), 32'(MAXV));
                        last_end = tcyc;
                    end
                    default: begin
                        check("abort_pulse", 32'(abort), 32'd1);
                        check("abort_no_done", 32'(done), 32'd0);
                        check("abort_lat", 32'(tcyc - gnt_cyc), 32'(mon_e.lat));
                        last_end = tcyc;
                    end
                endcase
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) cyc(1);
        check("drain_queue_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic set_start(input int i, input logic [W-1:0] v);
        req_start[i*W +: W] = v;
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({gnt, done, abort, busy, load, enab, cnt_in, owner}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check_all_zero("reset_outputs");

        // Single run, start 28: LOAD, COUNT 28..31, DONE 5 cycles after gnt
        set_start(1, 5'd28);
        req = 4'b0010;
        push(K_GNT, 4'b0010, 5'd28, 0);
        push(K_DONE, 4'b0010, 5'd0, 5);
        cyc(1);
        check("t1_load", 32'(load), 32'd1);
        check("t1_load_enab", 32'(enab), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("t1_cnt", 32'(cnt), 32'(28 + k));
            check("t1_enab", 32'(enab), 32'(k < 3));
            check("t1_no_load", 32'(load), 32'd0);
        end
        cyc(1);
        check("t1_done_busy", 32'(busy), 32'd1);
        req = '0;
        cyc(1);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_owner", 32'(owner), 32'd1);

        // Round robin, all requesting with start 30
        do_reset();
        for (int i = 0; i < N; i++) set_start(i, 5'd30);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            push(K_GNT, 4'(1 << (g % N)), 5'd30, 0);
            push(K_DONE, 4'(1 << (g % N)), 5'd0, 3);
        end
        drain(200);
        req = '0;
        cyc(2);

        // Start at MAX: one COUNT cycle with enab low
        do_reset();
        set_start(0, 5'd31);
        req = 4'b0001;
        push(K_GNT, 4'b0001, 5'd31, 0);
        push(K_DONE, 4'b0001, 5'd0, 2);
        cyc(2);
        check("t3_count_enab", 32'(enab), 32'd0);
        check("t3_count_busy", 32'(busy), 32'd1);
        check("t3_count_cnt", 32'(cnt), 32'd31);
        drain(20);
        req = '0;
        cyc(2);

        // Abort after 5 COUNT cycles; next grant must move to owner+1
        do_reset();
        set_start(0, 5'd0);
        set_start(1, 5'd29);
        req = 4'b0011;
        push(K_GNT, 4'b0001, 5'd0, 0);
        push(K_ABORT, 4'b0000, 5'd0, 6);
        push(K_GNT, 4'b0010, 5'd29, 0);
        push(K_DONE, 4'b0010, 5'd0, 4);
        cyc(6);
        req = 4'b0010;
        cyc(1);
        check("t4_abort", 32'(abort), 32'd1);
        check("t4_abort_enab", 32'(enab), 32'd0);
        check("t4_abort_cnt", 32'(cnt), 32'd5);
        req = 4'b0011;
        cyc(1);
        check("t4_idle_enab", 32'(enab), 32'd0);
        check("t4_idle_cnt", 32'(cnt), 32'd5);
        check("t4_idle_abort", 32'(abort), 32'd0);
        drain(50);
        req = '0;
        cyc(2);

        // Reset mid-run; pointer returns to 0
        set_start(2, 5'd10);
        req = 4'b1100;
        push(K_GNT, 4'b0100, 5'd10, 0);
        cyc(3);
        check("t5_pre_rst_enab", 32'(enab), 32'd1);
        rst = 1'b1;
        req = 4'b1001;
        set_start(0, 5'd30);
        cyc(1);
        check_all_zero("t5_rst_outputs");
        rst = 1'b0;
        push(K_GNT, 4'b0001, 5'd30, 0);
        push(K_DONE, 4'b0001, 5'd0, 3);
        drain(50);
        req = '0;
        cyc(2);

        // Ignored inputs during COUNT
        set_start(1, 5'd27);
        req = 4'b0010;
        push(K_GNT, 4'b0010, 5'd27, 0);
        push(K_DONE, 4'b0010, 5'd0, 6);
        cyc(2);
        set_start(1, 5'd3);
        req = 4'b1111;
        cyc(1);
        check("t6_cnt_in_latched", 32'(cnt_in), 32'd27);
        req = 4'b1011;
        cyc(1);
        req = 4'b0010;
        drain(50);
        req = '0;
        cyc(3);
        check("end_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
